// File: rtl/const_run_sequencer_pkg.sv
// Shared state encoding and helpers for the constants-unit run sequencer.
package const_run_sequencer_pkg;

    localparam int unsigned MEM_WORDS = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_WAIT = 3'd3,
        ST_FIN  = 3'd4
    } state_e;

    function automatic int unsigned clamp_len(input int unsigned len);
        return (len > MEM_WORDS) ? MEM_WORDS : len;
    endfunction

endpackage

// File: rtl/const_run_sequencer_if.sv
// Stream feed and unit-side memory-mapped/run signals of the run sequencer.
interface const_run_sequencer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic                  s_valid;
    logic [DATA_W-1:0]     s_data;
    logic                  s_ready;
    logic                  unit_valid;
    logic [ADDR_W-1:0]     unit_addr;
    logic [DATA_W/8-1:0]   unit_wstrb;
    logic [DATA_W-1:0]     unit_wdata;
    logic                  unit_ready;
    logic                  unit_run;
    logic                  unit_done;

    modport master (
        input  s_valid, s_data, unit_ready, unit_done,
        output s_ready, unit_valid, unit_addr, unit_wstrb, unit_wdata, unit_run
    );

    modport slave (
        output s_valid, s_data, unit_ready, unit_done,
        input  s_ready, unit_valid, unit_addr, unit_wstrb, unit_wdata, unit_run
    );
endinterface

// File: rtl/const_word_buf.sv
// One-entry buffer between the constant stream and the unit write port.
// A new word is accepted in the same cycle the held word drains.
module const_word_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);
    logic              full_q, full_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign in_ready  = !full_q || out_ready;
    assign out_valid = full_q;
    assign out_data  = data_q;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (full_q && out_ready) full_d = 1'b0;
        if (in_valid && in_ready) begin
            full_d = 1'b1;
            data_d = in_data;
        end
        if (flush) full_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end
endmodule

// File: rtl/const_run_sequencer.sv
// Loads constant words into a Versat constants unit, then issues run pulses
// and waits for done after each, with a watchdog against a hung unit.
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | streaming words into unit memory
//   RUN   | one-cycle run pulse
//   WAIT  | waiting for unit done
//   FIN   | one-cycle finished pulse
module const_run_sequencer
    import const_run_sequencer_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 6,
    parameter int RUNS_W = 8,
    parameter int WDOG_W = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           cfg_base,
    input  logic [LEN_W-1:0]            cfg_len,
    input  logic [RUNS_W-1:0]           cfg_runs,
    input  logic                        abort,
    const_run_sequencer_if.master       bus,
    output logic                        busy,
    output logic                        finished,
    output logic                        err,
    output logic [RUNS_W-1:0]           runs_done
);
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LEN_W-1:0]    len_q, len_d, len_c;
    logic [RUNS_W-1:0]   runs_q, runs_d;
    logic [LEN_W-1:0]    taken_q, taken_d;
    logic [LEN_W-1:0]    widx_q, widx_d;
    logic [RUNS_W-1:0]   runs_done_q, runs_done_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d, wdog_inc;
    logic                err_q, err_d;
    logic                flush, load_more, hs, wdog_stall;
    logic                buf_in_ready, buf_valid;
    logic [DATA_W-1:0]   buf_data;

    const_word_buf #(.DATA_W(DATA_W)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (bus.s_valid && load_more),
        .in_data   (bus.s_data),
        .in_ready  (buf_in_ready),
        .out_valid (buf_valid),
        .out_data  (buf_data),
        .out_ready (bus.unit_ready)
    );

    assign len_c          = LEN_W'(clamp_len(32'(cfg_len)));
    assign load_more      = (state_q == ST_LOAD) && (taken_q < len_q);
    assign bus.s_ready    = load_more && buf_in_ready;
    assign bus.unit_valid = buf_valid;
    assign bus.unit_addr  = buf_valid ? base_q + ADDR_W'(widx_q) : '0;
    assign bus.unit_wstrb = {(DATA_W/8){buf_valid}};
    assign bus.unit_wdata = buf_valid ? buf_data : '0;
    assign bus.unit_run   = (state_q == ST_RUN);
    assign busy           = (state_q != ST_IDLE);
    assign finished       = (state_q == ST_FIN);
    assign err            = err_q;
    assign runs_done      = runs_done_q;

    assign hs         = buf_valid && bus.unit_ready;
    assign wdog_stall = ((state_q == ST_LOAD) && buf_valid && !bus.unit_ready) || (state_q == ST_WAIT);
    assign wdog_inc   = wdog_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        runs_d      = runs_q;
        taken_d     = taken_q;
        widx_d      = widx_q;
        runs_done_d = runs_done_q;
        err_d       = err_q;
        flush       = 1'b0;
        wdog_d      = wdog_q;

        if (bus.s_valid && bus.s_ready) taken_d = taken_q + 1'b1;
        if (hs) widx_d = widx_q + 1'b1;
        if (hs) wdog_d = '0;
        else if (wdog_stall) wdog_d = wdog_inc;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d      = cfg_base;
                    len_d       = len_c;
                    runs_d      = cfg_runs;
                    taken_d     = '0;
                    widx_d      = '0;
                    runs_done_d = '0;
                    err_d       = 1'b0;
                    if (len_c != '0)         state_d = ST_LOAD;
                    else if (cfg_runs != '0) state_d = ST_RUN;
                    else                     state_d = ST_FIN;
                end
            end
            ST_LOAD: begin
                if (hs && (widx_q + 1'b1 == len_q)) begin
                    state_d = (runs_q != '0) ? ST_RUN : ST_FIN;
                end else if (wdog_stall && (&wdog_inc)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    flush   = 1'b1;
                end
            end
            ST_RUN: state_d = ST_WAIT;
            ST_WAIT: begin
                // wdog_q is zero only in the first WAIT cycle, where done is not trusted yet
                if ((wdog_q != '0) && bus.unit_done) begin
                    runs_done_d = runs_done_q + 1'b1;
                    state_d     = (runs_done_q + 1'b1 == runs_q) ? ST_FIN : ST_RUN;
                end else if (&wdog_inc) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            err_d       = 1'b1;
            flush       = 1'b1;
            widx_d      = widx_q;
            taken_d     = taken_q;
            runs_done_d = runs_done_q;
        end

        if (state_d != state_q) wdog_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            runs_q      <= '0;
            taken_q     <= '0;
            widx_q      <= '0;
            runs_done_q <= '0;
            wdog_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            runs_q      <= runs_d;
            taken_q     <= taken_d;
            widx_q      <= widx_d;
            runs_done_q <= runs_done_d;
            wdog_q      <= wdog_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_const_run_sequencer.sv
// Directed bench for const_run_sequencer with an expected-write queue model.
module tb_const_run_sequencer;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 6;
    localparam int RUNS_W = 8;
    localparam int WDOG_W = 12;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic [ADDR_W-1:0] cfg_base;
    logic [LEN_W-1:0]  cfg_len;
    logic [RUNS_W-1:0] cfg_runs;
    logic busy, finished, err;
    logic [RUNS_W-1:0] runs_done;

    const_run_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    const_run_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .RUNS_W(RUNS_W), .WDOG_W(WDOG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_base  (cfg_base),
        .cfg_len   (cfg_len),
        .cfg_runs  (cfg_runs),
        .abort     (abort),
        .bus       (bus),
        .busy      (busy),
        .finished  (finished),
        .err       (err),
        .runs_done (runs_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // model state: expected writes in order, stream words still to offer
    int exp_aq[$];
    int exp_dq[$];
    int src_q[$];
    int wr_cnt, run_cnt, fin_cnt;
    int first_addr, last_addr, last_data;
    int rdy_mode = 0, rdy_limit = 0, hs_total = 0, done_dly = 3;
    bit rand_sv = 1'b0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // environment: stream source and unit responder
    initial begin
        bit beat, hs, runp;
        int done_cnt;
        int dummy;
        done_cnt = 0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.unit_ready = 1'b1;
        bus.unit_done = 1'b0;
        forever begin
            @(negedge clk);
            beat = bus.s_valid && bus.s_ready;
            hs   = bus.unit_valid && bus.unit_ready;
            runp = bus.unit_run;
            @(posedge clk);
            #1;
            if (beat && src_q.size() > 0) dummy = src_q.pop_front();
            if (hs) hs_total++;
            case (rdy_mode)
                0:       bus.unit_ready = 1'b1;
                1:       bus.unit_ready = !bus.unit_ready;
                default: bus.unit_ready = (hs_total < rdy_limit);
            endcase
            if (runp) begin
                bus.unit_done = 1'b0;
                done_cnt = done_dly;
            end else if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) bus.unit_done = 1'b1;
            end
            bus.s_valid = (src_q.size() > 0) && (rand_sv ? ($urandom_range(0, 1) == 1) : 1'b1);
            bus.s_data  = (src_q.size() > 0) ? DATA_W'(src_q[0]) : '0;
        end
    end

    // compare process
    initial begin
        bit held_v;
        int held_a, held_d, ea, ed;
        held_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 1'b0;
            end else begin
                if (bus.unit_valid) begin
                    chk("wstrb_write", bus.unit_wstrb, 4'hF);
                    if (held_v) begin
                        chk("hold_addr", bus.unit_addr, held_a);
                        chk("hold_data", bus.unit_wdata, held_d);
                    end
                    if (bus.unit_ready) begin
                        chk("write_expected", exp_aq.size() > 0, 1);
                        if (exp_aq.size() > 0) begin
                            ea = exp_aq.pop_front();
                            ed = exp_dq.pop_front();
                            chk("write_addr", bus.unit_addr, ea);
                            chk("write_data", bus.unit_wdata, ed);
                        end
                        if (wr_cnt == 0) first_addr = int'(bus.unit_addr);
                        last_addr = int'(bus.unit_addr);
                        last_data = int'(bus.unit_wdata);
                        wr_cnt++;
                        held_v = 1'b0;
                    end else begin
                        held_v = 1'b1;
                        held_a = int'(bus.unit_addr);
                        held_d = int'(bus.unit_wdata);
                    end
                end else begin
                    chk("wstrb_idle", bus.unit_wstrb, 0);
                    held_v = 1'b0;
                end
                if (bus.unit_run) begin
                    run_cnt++;
                    chk("run_without_write", bus.unit_valid, 0);
                end
                if (finished) fin_cnt++;
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_s_ready"}, bus.s_ready, 0);
        chk({tag, "_unit_valid"}, bus.unit_valid, 0);
        chk({tag, "_unit_addr"}, bus.unit_addr, 0);
        chk({tag, "_unit_wstrb"}, bus.unit_wstrb, 0);
        chk({tag, "_unit_wdata"}, bus.unit_wdata, 0);
        chk({tag, "_unit_run"}, bus.unit_run, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_finished"}, finished, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_runs_done"}, runs_done, 0);
    endtask

    task automatic start_job(input int base, input int len, input int runs);
        @(posedge clk);
        #1;
        wr_cnt = 0;
        run_cnt = 0;
        fin_cnt = 0;
        cfg_base = ADDR_W'(base);
        cfg_len  = LEN_W'(len);
        cfg_runs = RUNS_W'(runs);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("start_busy", busy, 1);
        chk("start_clears_err", err, 0);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic load_model(input int base, input int len, input int dbase);
        int n;
        n = (len > 32) ? 32 : len;
        exp_aq.delete();
        exp_dq.delete();
        src_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_aq.push_back((base + i) % 1024);
            exp_dq.push_back(dbase + i);
            src_q.push_back(dbase + i);
        end
    endtask

    task automatic run_job(input int base, input int len, input int runs, input int dly,
                           input int dbase, input int rmode, input bit rsv);
        bit ok;
        int n;
        n = (len > 32) ? 32 : len;
        load_model(base, len, dbase);
        rdy_mode = rmode;
        rand_sv = rsv;
        done_dly = dly;
        start_job(base, len, runs);
        wait_idle(ok);
        chk("job_completes", ok, 1);
        @(negedge clk);
        chk("writes_left", exp_aq.size(), 0);
        chk("write_count", wr_cnt, n);
        chk("run_pulses", run_cnt, runs);
        chk("finished_pulses", fin_cnt, 1);
        chk("err_after_job", err, 0);
        chk("runs_done", runs_done, runs);
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cfg_base = '0;
        cfg_len = '0;
        cfg_runs = '0;
        @(negedge clk);
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // basic load and run
        run_job(4, 3, 2, 3, 'hA, 0, 1'b0);
        chk("basic_first_addr", first_addr, 4);
        chk("basic_last_addr", last_addr, 6);
        chk("basic_last_data", last_data, 'hC);
        chk("basic_runs_done", runs_done, 2);

        // backpressure on both sides
        run_job(100, 7, 1, 2, 'h1000, 1, 1'b1);
        chk("bp_write_count", wr_cnt, 7);

        // clamp and address wrap
        run_job(1020, 40, 1, 1, 'h2000, 0, 1'b0);
        chk("clamp_count", wr_cnt, 32);
        chk("wrap_first_addr", first_addr, 1020);
        chk("wrap_last_addr", last_addr, 27);

        // run-only then load-only
        run_job(50, 0, 1, 2, 0, 0, 1'b0);
        chk("run_only_writes", wr_cnt, 0);
        run_job(60, 2, 0, 2, 'h3000, 0, 1'b0);
        chk("load_only_runs", run_cnt, 0);

        // watchdog on a hung unit
        load_model(0, 0, 0);
        done_dly = 0;
        start_job(0, 0, 1);
        for (int i = 0; i < 20 && !bus.unit_run; i++) @(negedge clk);
        chk("wdog_run_seen", bus.unit_run, 1);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (busy && cnt < 5000);
        chk("wdog_cycles_to_idle", cnt, 4096);
        chk("wdog_err", err, 1);
        @(negedge clk);
        chk("wdog_no_finished", fin_cnt, 0);
        chk("wdog_runs_done", runs_done, 0);

        // next start clears err (checked inside start_job)
        run_job(10, 1, 1, 2, 'h4000, 0, 1'b0);

        // abort mid-LOAD after one write, with the second word pending
        load_model(200, 3, 'h5000);
        done_dly = 2;
        rdy_limit = hs_total + 1;
        rdy_mode = 2;
        start_job(200, 3, 1);
        for (int i = 0; i < 50 && !(bus.unit_valid && bus.unit_ready); i++) @(negedge clk);
        chk("abort_first_write_seen", bus.unit_valid && bus.unit_ready, 1);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_err", err, 1);
        chk("abort_unit_valid", bus.unit_valid, 0);
        chk("abort_writes", wr_cnt, 1);
        exp_aq.delete();
        exp_dq.delete();
        src_q.delete();
        rdy_mode = 0;

        // reset while waiting for done
        done_dly = 0;
        start_job(300, 0, 1);
        repeat (4) @(negedge clk);
        chk("rst_pre_busy", busy, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_zero("midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
